// File: rtl/ewb_pmem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// lc3b_types : shared types for the L2 / eviction-write-buffer memory arbiter.
//   lc3b_word   - 16-bit address word
//   lc3b_line   - 128-bit cache line
//   arb_state_t - arbiter FSM state encoding
// No ports (package).
// ----------------------------------------------------------------------------
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_FWD   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/ewb_pmem_arbiter_if.sv
// ----------------------------------------------------------------------------
// ewb_pmem_arbiter_if : physical-memory bus between the arbiter and pmem.
//   pmem_read / pmem_write   - request strobes (arbiter -> memory)
//   pmem_address / pmem_wdata - request address and write line
//   pmem_rdata / pmem_resp   - read line and one-cycle completion pulse
// Modports: master (arbiter side), slave (memory side).
// ----------------------------------------------------------------------------
interface ewb_pmem_arbiter_if;
    import lc3b_types::*;

    logic     pmem_read;
    logic     pmem_write;
    lc3b_word pmem_address;
    lc3b_line pmem_wdata;
    lc3b_line pmem_rdata;
    logic     pmem_resp;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/ewb_pmem_arbiter_starve.sv
// ----------------------------------------------------------------------------
// arb_starve_counter : saturating count of read grants taken while a
// writeback is waiting.
//   clk, reset - clock, synchronous active-high reset
//   inc        - one read completed while the writeback was pending
//   clr        - writeback completed or no writeback pending (wins over inc)
//   sat        - count has reached LIMIT
//   count      - current count (debug visibility)
// ----------------------------------------------------------------------------
module arb_starve_counter #(
    parameter int LIMIT = 4,
    localparam int CW   = $clog2(LIMIT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic          sat,
    output logic [CW-1:0] count
);

    assign sat = (count == CW'(LIMIT));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ewb_pmem_arbiter.sv
// ----------------------------------------------------------------------------
// ewb_pmem_arbiter : shares one physical-memory port between L2 line fills
// and eviction-write-buffer writebacks.
//   clk, reset        - clock, synchronous active-high reset
//   l2_pmem_*         - L2 fill request (read/address in, rdata/resp out)
//   ewb_*             - writeback request (valid/address/wdata in, done out)
//   pmem              - physical-memory bus (master modport)
//   state_dbg         - current FSM state
//   starve_dbg        - current starve count
// Build option: define EWB_FORWARD_EN to serve a fill that hits the buffered
// line straight from ewb_wdata (S_FWD) instead of writing back first.
//
// Handshake: a requester raises its request (l2_pmem_read / ewb_valid) and
// holds it and its address/data stable until it sees its one-cycle
// completion pulse (l2_pmem_resp / ewb_done); the arbiter likewise holds its
// pmem strobe stable until pmem_resp, and pmem_resp is ignored unless a
// strobe is up. Every completion returns to S_IDLE, so grants are always
// separated by at least one idle cycle.
// ----------------------------------------------------------------------------
module ewb_pmem_arbiter
    import lc3b_types::*;
#(
    parameter int STARVE_LIMIT = 4,
    localparam int CW          = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                l2_pmem_read,
    input  lc3b_word            l2_pmem_address,
    output lc3b_line            l2_pmem_rdata,
    output logic                l2_pmem_resp,
    input  logic                ewb_valid,
    input  lc3b_word            ewb_address,
    input  lc3b_line            ewb_wdata,
    output logic                ewb_done,
    ewb_pmem_arbiter_if.master  pmem,
    output arb_state_t          state_dbg,
    output logic [CW-1:0]       starve_dbg
);

    arb_state_t state, next_state;
    logic       line_match;
    logic       starve_sat;
    logic       starve_inc, starve_clr;

    logic       pmem_read_c, pmem_write_c;
    lc3b_word   pmem_address_c;
    lc3b_line   pmem_wdata_c;

    // A fill that targets the line sitting in the write buffer must never be
    // served from (stale) memory.
    assign line_match = l2_pmem_read && ewb_valid &&
                        (l2_pmem_address[15:4] == ewb_address[15:4]);

    assign starve_inc = (state == S_READ)  && pmem.pmem_resp && ewb_valid;
    assign starve_clr = ((state == S_WRITE) && pmem.pmem_resp) || !ewb_valid;

    arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .sat   (starve_sat),
        .count (starve_dbg)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (line_match) begin
`ifdef EWB_FORWARD_EN
                    next_state = S_FWD;
`else
                    next_state = S_WRITE;
`endif
                end else if (ewb_valid && starve_sat) begin
                    next_state = S_WRITE;
                end else if (l2_pmem_read) begin
                    next_state = S_READ;
                end else if (ewb_valid) begin
                    next_state = S_WRITE;
                end
            end
            S_READ:  if (pmem.pmem_resp) next_state = S_IDLE;
            // Completes even if ewb_valid drops mid-write.
            S_WRITE: if (pmem.pmem_resp) next_state = S_IDLE;
            S_FWD:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic. Everything is forced low while reset is asserted so an
    // interrupted transaction is dropped in the very cycle reset is seen.
    always_comb begin
        pmem_read_c    = 1'b0;
        pmem_write_c   = 1'b0;
        pmem_address_c = '0;
        pmem_wdata_c   = '0;
        l2_pmem_rdata  = '0;
        l2_pmem_resp   = 1'b0;
        ewb_done       = 1'b0;
        if (!reset) begin
            case (state)
                S_READ: begin
                    pmem_read_c    = 1'b1;
                    pmem_address_c = l2_pmem_address;
                    l2_pmem_rdata  = pmem.pmem_rdata;
                    l2_pmem_resp   = pmem.pmem_resp;
                end
                S_WRITE: begin
                    pmem_write_c   = 1'b1;
                    pmem_address_c = ewb_address;
                    pmem_wdata_c   = ewb_wdata;
                    ewb_done       = pmem.pmem_resp;
                end
                S_FWD: begin
`ifdef EWB_FORWARD_EN
                    l2_pmem_rdata  = ewb_wdata;
                    l2_pmem_resp   = 1'b1;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign pmem.pmem_read    = pmem_read_c;
    assign pmem.pmem_write   = pmem_write_c;
    assign pmem.pmem_address = pmem_address_c;
    assign pmem.pmem_wdata   = pmem_wdata_c;
    assign state_dbg         = state;

endmodule

// File: tb/tb_ewb_pmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ewb_pmem_arbiter : directed bench for ewb_pmem_arbiter (STARVE_LIMIT=4).
// Honours EWB_FORWARD_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_ewb_pmem_arbiter;
    import lc3b_types::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic       l2_pmem_read;
    lc3b_word   l2_pmem_address;
    lc3b_line   l2_pmem_rdata;
    logic       l2_pmem_resp;
    logic       ewb_valid;
    lc3b_word   ewb_address;
    lc3b_line   ewb_wdata;
    logic       ewb_done;
    arb_state_t state_dbg;
    logic [2:0] starve_dbg;

    ewb_pmem_arbiter_if pif ();

    ewb_pmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .l2_pmem_read    (l2_pmem_read),
        .l2_pmem_address (l2_pmem_address),
        .l2_pmem_rdata   (l2_pmem_rdata),
        .l2_pmem_resp    (l2_pmem_resp),
        .ewb_valid       (ewb_valid),
        .ewb_address     (ewb_address),
        .ewb_wdata       (ewb_wdata),
        .ewb_done        (ewb_done),
        .pmem            (pif.master),
        .state_dbg       (state_dbg),
        .starve_dbg      (starve_dbg)
    );

    // ---------------- checking ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor / scoreboard state ----------------
    logic [16:0] exp_q[$];
    logic [16:0] act_q[$];
    int          cyc = 0;
    int          rd_cycles, wr_cycles, l2_resp_cnt, ewb_done_cnt;
    int          first_rd, first_wr, l2_resp_cyc;
    int          viol = 0;
    lc3b_word    rd_addr_seen, wr_addr_seen;
    lc3b_line    wr_data_seen, last_l2_data;
    logic [2:0]  max_starve;
    logic        prev_done = 1'b0;

    // ---------------- agent / responder controls ----------------
    int   reads_left = 0;
    int   rd_lat = 3;
    int   wr_lat = 3;
    logic spur = 1'b0;

    task automatic clear_mon();
        rd_cycles = 0; wr_cycles = 0; l2_resp_cnt = 0; ewb_done_cnt = 0;
        first_rd = -1; first_wr = -1; l2_resp_cyc = -1;
        rd_addr_seen = '0; wr_addr_seen = '0; wr_data_seen = '0; last_l2_data = '0;
        max_starve = '0;
        exp_q.delete();
        act_q.delete();
    endtask

    task automatic sb_compare(input string tag);
        check({tag, "_sb_len"}, 128'(act_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            check($sformatf("%s_sb_%0d", tag, i), 128'(act_q[i]), 128'(exp_q[i]));
        end
    endtask

    // Monitor samples at negedge; requester agents and pmem responder drive
    // 1 time unit after posedge.
    initial begin : env
        logic saw_l2, saw_ewb;
        int   cnt;
        cnt = 0;
        pif.pmem_resp  = 1'b0;
        pif.pmem_rdata = '0;
        clear_mon();
        forever begin
            @(negedge clk);
            cyc++;
            if (pif.pmem_read) begin
                rd_cycles++;
                if (first_rd < 0) begin first_rd = cyc; rd_addr_seen = pif.pmem_address; end
            end
            if (pif.pmem_write) begin
                wr_cycles++;
                if (first_wr < 0) begin
                    first_wr = cyc; wr_addr_seen = pif.pmem_address; wr_data_seen = pif.pmem_wdata;
                end
            end
            if (pif.pmem_read && pif.pmem_write) viol++;
            if (prev_done && (pif.pmem_read || pif.pmem_write || l2_pmem_resp)) viol++;
            prev_done = l2_pmem_resp || ewb_done;
            if (l2_pmem_resp) begin
                l2_resp_cnt++;
                last_l2_data = l2_pmem_rdata;
                l2_resp_cyc  = cyc;
                act_q.push_back({1'b0, l2_pmem_address});
            end
            if (ewb_done) begin
                ewb_done_cnt++;
                act_q.push_back({1'b1, ewb_address});
            end
            if (starve_dbg > max_starve) max_starve = starve_dbg;
            saw_l2  = l2_pmem_resp;
            saw_ewb = ewb_done;

            @(posedge clk);
            #1;
            if (saw_l2) begin
                if (reads_left > 1) begin
                    reads_left--;
                    l2_pmem_address = l2_pmem_address + 16'h0010;
                end else begin
                    reads_left   = 0;
                    l2_pmem_read = 1'b0;
                end
            end
            if (saw_ewb) ewb_valid = 1'b0;
            if (pif.pmem_read || pif.pmem_write) begin
                cnt++;
                pif.pmem_resp = (cnt == (pif.pmem_write ? wr_lat : rd_lat)) || spur;
                if (pif.pmem_read) pif.pmem_rdata = {8{pif.pmem_address}};
            end else begin
                cnt = 0;
                pif.pmem_resp = spur;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_quiet(input int budget, input string tag);
        int k;
        k = 0;
        while ((l2_pmem_read || ewb_valid) && k < budget) begin
            tick(1);
            k++;
        end
        tick(3);
        check({tag, "_done_in_time"}, 128'(k < budget), 128'(1));
    endtask

    task automatic start_read(input lc3b_word a, input int n);
        l2_pmem_address = a;
        reads_left      = n;
        l2_pmem_read    = 1'b1;
    endtask

    task automatic start_ewb(input lc3b_word a, input lc3b_line d);
        ewb_address = a;
        ewb_wdata   = d;
        ewb_valid   = 1'b1;
    endtask

    // ---------------- directed vectors ----------------
    localparam lc3b_line D1230 = 128'h1230_1230_1230_1230_1230_1230_1230_1230;
    localparam lc3b_line D1238 = 128'h1238_1238_1238_1238_1238_1238_1238_1238;
    localparam lc3b_line W2    = 128'hA5A5_0002_0000_FFFF_0123_4567_89AB_CDEF;
    localparam lc3b_line W4    = 128'hBEEF_0004_CAFE_F00D_1111_2222_3333_4444;

    initial begin : test
        int start_cyc;
        int k;
        l2_pmem_read = 1'b0; l2_pmem_address = '0;
        ewb_valid = 1'b0; ewb_address = '0; ewb_wdata = '0;

        // Reset state, checked while reset is still asserted.
        reset = 1'b1;
        tick(2);
        @(negedge clk);
        check("rst_state",     128'(state_dbg),        128'(S_IDLE));
        check("rst_pmem_rd",   128'(pif.pmem_read),    128'(0));
        check("rst_pmem_wr",   128'(pif.pmem_write),   128'(0));
        check("rst_l2_resp",   128'(l2_pmem_resp),     128'(0));
        check("rst_ewb_done",  128'(ewb_done),         128'(0));
        check("rst_pmem_addr", 128'(pif.pmem_address), 128'(0));
        check("rst_l2_rdata",  l2_pmem_rdata,          128'(0));
        check("rst_starve",    128'(starve_dbg),       128'(0));
        tick(1);
        reset = 1'b0;
        tick(2);

        // Read only: 0x1230, memory answers in the 3rd strobe cycle.
        clear_mon();
        start_cyc = cyc;
        start_read(16'h1230, 1);
        exp_q.push_back({1'b0, 16'h1230});
        wait_quiet(50, "rd");
        check("rd_strobe_cycles", 128'(rd_cycles),             128'(3));
        check("rd_no_write",      128'(wr_cycles),             128'(0));
        check("rd_addr",          128'(rd_addr_seen),          128'(16'h1230));
        check("rd_resp_pulses",   128'(l2_resp_cnt),           128'(1));
        check("rd_data",          last_l2_data,                D1230);
        check("rd_grant_latency", 128'(first_rd - start_cyc),  128'(2));
        check("rd_resp_latency",  128'(l2_resp_cyc - start_cyc), 128'(4));
        sb_compare("rd");

        // Simultaneous read and writeback: read first.
        clear_mon();
        start_ewb(16'h4000, W2);
        start_read(16'h1230, 1);
        exp_q.push_back({1'b0, 16'h1230});
        exp_q.push_back({1'b1, 16'h4000});
        wait_quiet(60, "sim");
        check("sim_read_first", 128'(first_rd < first_wr), 128'(1));
        check("sim_done_pulses", 128'(ewb_done_cnt),       128'(1));
        check("sim_wr_addr",     128'(wr_addr_seen),       128'(16'h4000));
        check("sim_wr_data",     wr_data_seen,             W2);
        check("sim_wr_cycles",   128'(wr_cycles),          128'(3));
        sb_compare("sim");

        // Starvation: 5 back-to-back reads with a writeback waiting.
        clear_mon();
        start_ewb(16'h4000, W2);
        start_read(16'h1000, 5);
        exp_q.push_back({1'b0, 16'h1000});
        exp_q.push_back({1'b0, 16'h1010});
        exp_q.push_back({1'b0, 16'h1020});
        exp_q.push_back({1'b0, 16'h1030});
        exp_q.push_back({1'b1, 16'h4000});
        exp_q.push_back({1'b0, 16'h1040});
        wait_quiet(200, "stv");
        check("stv_max_count",  128'(max_starve),   128'(4));
        check("stv_rd_cycles",  128'(rd_cycles),    128'(15));
        check("stv_done",       128'(ewb_done_cnt), 128'(1));
        check("stv_count_end",  128'(starve_dbg),   128'(0));
        sb_compare("stv");

        // Hazard: fill hits the buffered line.
        clear_mon();
        start_cyc = cyc;
        start_ewb(16'h1230, W4);
        start_read(16'h1238, 1);
`ifdef EWB_FORWARD_EN
        exp_q.push_back({1'b0, 16'h1238});
        exp_q.push_back({1'b1, 16'h1230});
        wait_quiet(60, "haz");
        check("haz_no_pmem_read", 128'(rd_cycles),               128'(0));
        check("haz_fwd_latency",  128'(l2_resp_cyc - start_cyc), 128'(2));
        check("haz_fwd_data",     last_l2_data,                  W4);
        check("haz_wr_after",     128'(first_wr > l2_resp_cyc),  128'(1));
`else
        exp_q.push_back({1'b1, 16'h1230});
        exp_q.push_back({1'b0, 16'h1238});
        wait_quiet(60, "haz");
        check("haz_write_first", 128'(first_wr < first_rd), 128'(1));
        check("haz_wr_data",     wr_data_seen,              W4);
        check("haz_rd_data",     last_l2_data,              D1238);
`endif
        sb_compare("haz");

        // Spurious pmem_resp in S_IDLE is ignored.
        spur = 1'b1;
        tick(1);
        @(negedge clk);
        check("spur_l2_resp",  128'(l2_pmem_resp), 128'(0));
        check("spur_ewb_done", 128'(ewb_done),     128'(0));
        tick(1);
        spur = 1'b0;
        tick(1);
        @(negedge clk);
        check("spur_state", 128'(state_dbg), 128'(S_IDLE));
        tick(1);

        // Reset in the middle of a writeback.
        clear_mon();
        wr_lat = 20;
        start_ewb(16'h4000, W2);
        start_read(16'h2000, 1);
        k = 0;
        while (!pif.pmem_write && k < 40) begin
            tick(1);
            k++;
        end
        check("mid_wr_reached", 128'(pif.pmem_write), 128'(1));
        check("mid_wr_count",   128'(starve_dbg),     128'(1));
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_wr_low", 128'(pif.pmem_write), 128'(0));
        tick(1);
        reset     = 1'b0;
        ewb_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_state",  128'(state_dbg),      128'(S_IDLE));
        check("mid_rst_count",  128'(starve_dbg),     128'(0));
        check("mid_rst_wr_off", 128'(pif.pmem_write), 128'(0));
        tick(25);
        check("mid_rst_no_done", 128'(ewb_done_cnt), 128'(0));
        wr_lat = 3;

        check("protocol_violations", 128'(viol), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
